riscv_mem_arbiter: RTL and testbench
====================================

# riscv_mem_arbiter

Two-requester arbiter that shares the RV32I core's single-port, word-wide unified memory between the instruction-fetch unit and the load/store unit. Each cycle it accepts at most one request. It drives the memory port, tracks which requester owns the in-flight access, and returns the read data or write acknowledgement exactly one cycle later. It also range- and alignment-checks every request, so illegal accesses never reach the memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data and address width; equals `REG_WIDTH`.
- `MEM_WIDTH`, 4: bytes per memory word; also the byte-enable width.
- `MEM_SIZE`, 65536: memory size in bytes.
- `HALF_MEM`, 32768: instruction/data split; fetches are legal only below this byte address.
- `WADDR_W`, $clog2(MEM_SIZE/MEM_WIDTH) = 14: word-address width.

Ports (clock is `clk`; reset is `rst`, asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch response valid.
- `if_rdata` out 32: fetched word.
- `if_err` out 1: fetch error; valid with `if_rvalid`.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: store byte enables.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data response valid.
- `d_rdata` out 32: load data; 0 for stores and errors.
- `d_err` out 1: data error; valid with `d_rvalid`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out 14: word address = byte address[15:2].
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read word, valid the cycle after `mem_en`.

## Operation
- **Request/grant:** a request is accepted on the rising edge where req && gnt. Grants are combinational from the req inputs and the priority state. At most one gnt is high per cycle, and no gnt is high while `rst` is high.
- **Fixed priority (default):** if both requesters ask in the same cycle, data wins.
- **Legality:**
  - A fetch is illegal if `if_addr[1:0]` ≠ 0 or `if_addr` ≥ `HALF_MEM`.
  - A data access is illegal if `d_addr[1:0]` ≠ 0 or `d_addr` ≥ `MEM_SIZE`.
  - A store with `d_be` = 0 is legal and performs no write: `mem_en` = 1, `mem_be` = 0.
- **Legal accepted request:** in the grant cycle, `mem_en` = 1 and `mem_we`/`mem_be`/`mem_wdata` come from the winner. For loads and fetches, `mem_we` = 0 and `mem_be` = 4'hF.
- **Illegal accepted request:** it is still granted (gnt = 1), but `mem_en` stays 0. The response carries err = 1 and rdata = 0.
- **Response state:** registered `rsp_valid`, `rsp_owner` (IF/D), `rsp_err` and `rsp_is_store`.
  - In the response cycle, the owner's rvalid = 1.
  - rdata = `mem_rdata` for legal reads; otherwise 0.
- **Throughput:** fully pipelined, one accept per cycle. A new grant may coincide with the previous request's response cycle.
- **Idle outputs:** when `mem_en` = 0, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are driven to 0.

## Timing
- **Latency:** exactly 1 cycle from accept edge to rvalid for both legal and illegal requests. rvalid is a single-cycle pulse with no stall or backpressure on responses.
- **Reset values:** `rsp_valid` = 0 and the round-robin pointer = "data last". All gnt, rvalid, err and rdata outputs are 0 and all `mem_*` outputs are 0.
- **Reset mid-operation:** asserting `rst` while a response is pending discards that response; no rvalid is produced after reset.
- **Starvation:** without the configuration feature, a data requester asserting `d_req` every cycle starves fetch indefinitely. This is intentional.
- **Simultaneous accept and response:** the response to request N and the grant of request N+1 can occur in the same cycle, to the same or different requesters.

## Configuration
- Macro: `RISCV_ARB_RR_EN`.
- **Defined:** round-robin on conflict. A 1-bit `last_winner` register updates on every accept. When both requesters ask, the one that did not win last is granted. When only one asks, it is granted regardless of `last_winner`.
- **Undefined:** fixed data priority, and the `last_winner` register is not built.

## Test plan
- **Single legal load:** reset, then `d_req` with `d_addr` = 0x0000_8004 and memory word 1 = 0xDEADBEEF → `d_gnt` = 1, `mem_addr` = 0x2001, `mem_en` = 1; next cycle `d_rvalid` = 1, `d_rdata` = 0xDEADBEEF, `d_err` = 0.
- **Store then fetch of the same word:** store `d_be` = 4'b0011, `d_wdata` = 0x12345678 to 0x100 over an old word of 0xAAAAAAAA; then fetch 0x100 → `if_rdata` = 0xAAAA5678, with back-to-back grants on consecutive cycles.
- **Conflict:** `if_req` and `d_req` both held for 4 cycles.
  - Fixed priority: grant sequence D, D, D, D.
  - With `RISCV_ARB_RR_EN`: grant sequence IF, D, IF, D, since the pointer resets to "data last".
- **Illegal accesses:** fetch at 0x8000, load at 0x0002, load at 0x10000 → each is granted with `mem_en` = 0, then rvalid with err = 1 and rdata = 0.
- **Reset mid-operation:** accept a load, assert `rst` before the response edge → no rvalid ever appears and all outputs read 0 during and after reset.
- **Idle:** no requests for 10 cycles → `mem_en` = 0, `mem_addr` = 0, and no gnt or rvalid is asserted.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Request/response bundle between the IF unit, the LSU, the unified memory and riscv_mem_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface riscv_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 4,
  parameter int WADDR_W    = 14
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic                  d_we;
  logic [MEM_WIDTH-1:0]  d_be;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_WIDTH-1:0]  mem_be;
  logic [WADDR_W-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares the single-port unified memory between fetch and load/store; one accept per cycle, 1-cycle response.
// Data wins conflicts by default; define RISCV_ARB_RR_EN for round-robin on conflict.
module riscv_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 4,
  parameter int MEM_SIZE   = 65536,
  parameter int HALF_MEM   = 32768,
  parameter int WADDR_W    = $clog2(MEM_SIZE / MEM_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_mem_arbiter_if.slave     bus
);
  localparam int OFF = $clog2(MEM_WIDTH);

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  logic   rsp_valid_q, rsp_valid_d;
  owner_e rsp_owner_q, rsp_owner_d;
  logic   rsp_err_q, rsp_err_d;
  logic   rsp_is_store_q, rsp_is_store_d;

  logic if_legal, d_legal;
  logic if_win, d_win;
  logic if_gnt, d_gnt;

`ifdef RISCV_ARB_RR_EN
  owner_e last_winner_q, last_winner_d;
`endif

  always_comb begin
    if_legal = (bus.if_addr[OFF-1:0] == '0) && (bus.if_addr < DATA_WIDTH'(HALF_MEM));
    d_legal  = (bus.d_addr[OFF-1:0] == '0) && (bus.d_addr < DATA_WIDTH'(MEM_SIZE));
`ifdef RISCV_ARB_RR_EN
    // On conflict, the requester that did not win last time goes first.
    d_win = bus.d_req && (!bus.if_req || (last_winner_q == OWN_IF));
`else
    d_win = bus.d_req;
`endif
    if_win = bus.if_req && !d_win;
    d_gnt  = d_win && !rst;
    if_gnt = if_win && !rst;
  end

  assign bus.d_gnt  = d_gnt;
  assign bus.if_gnt = if_gnt;

  // Illegal requests are granted but never strobe the memory.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_gnt) begin
      if (d_legal) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_be    = bus.d_we ? bus.d_be : {MEM_WIDTH{1'b1}};
        bus.mem_addr  = bus.d_addr[WADDR_W+OFF-1:OFF];
        bus.mem_wdata = bus.d_wdata;
      end
    end else if (if_gnt && if_legal) begin
      bus.mem_en   = 1'b1;
      bus.mem_be   = {MEM_WIDTH{1'b1}};
      bus.mem_addr = bus.if_addr[WADDR_W+OFF-1:OFF];
    end
  end

  always_comb begin
    rsp_valid_d    = d_gnt || if_gnt;
    rsp_owner_d    = d_gnt ? OWN_D : OWN_IF;
    rsp_err_d      = d_gnt ? !d_legal : !if_legal;
    rsp_is_store_d = d_gnt && bus.d_we;
`ifdef RISCV_ARB_RR_EN
    last_winner_d  = rsp_valid_d ? rsp_owner_d : last_winner_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_owner_q    <= OWN_IF;
      rsp_err_q      <= 1'b0;
      rsp_is_store_q <= 1'b0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_owner_q    <= rsp_owner_d;
      rsp_err_q      <= rsp_err_d;
      rsp_is_store_q <= rsp_is_store_d;
    end
  end

`ifdef RISCV_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner_q <= OWN_D;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`endif

  always_comb begin
    bus.if_rvalid = rsp_valid_q && (rsp_owner_q == OWN_IF);
    bus.d_rvalid  = rsp_valid_q && (rsp_owner_q == OWN_D);
    bus.if_err    = bus.if_rvalid && rsp_err_q;
    bus.d_err     = bus.d_rvalid && rsp_err_q;
    bus.if_rdata  = (bus.if_rvalid && !rsp_err_q) ? bus.mem_rdata : '0;
    bus.d_rdata   = (bus.d_rvalid && !rsp_err_q && !rsp_is_store_q) ? bus.mem_rdata : '0;
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter with a behavioural word memory on the mem_* port.
module tb_riscv_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if bus ();
  riscv_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        own_d;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0] mem       [0:16383];
  logic [31:0] model_mem [0:16383];
  rsp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        last_d;
  logic [3:0]  gseq;
  logic [31:0] last_rdata;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_if_gnt"},   32'(bus.if_gnt), 32'd0);
    check_val({tag, "_d_gnt"},    32'(bus.d_gnt), 32'd0);
    check_val({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    check_val({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
    check_val({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    check_val({tag, "_d_rdata"},  bus.d_rdata, 32'd0);
    check_val({tag, "_errs"},     32'({bus.if_err, bus.d_err}), 32'd0);
    check_val({tag, "_mem_en"},   32'({bus.mem_en, bus.mem_we, bus.mem_be}), 32'd0);
    check_val({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    bus.if_req = ir; bus.if_addr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_be = be; bus.d_addr = da; bus.d_wdata = wd;
  endtask

  // One clock cycle: drive at negedge, check grant/memory port, check response after the edge.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    logic il, dl, eg_i, eg_d, e_en, e_we;
    logic [3:0]  e_be;
    logic [13:0] e_addr;
    rsp_t r;
    @(negedge clk);
    drive(ir, ia, dr, dw, be, da, wd);
    #1;
    il = (ia[1:0] == 2'b00) && (ia < 32'h0000_8000);
    dl = (da[1:0] == 2'b00) && (da < 32'h0001_0000);
`ifdef RISCV_ARB_RR_EN
    if (dr && ir) eg_d = !last_d;
    else          eg_d = dr;
`else
    eg_d = dr;
`endif
    eg_i = ir && !eg_d;
    check_val("if_gnt", 32'(bus.if_gnt), 32'(eg_i));
    check_val("d_gnt",  32'(bus.d_gnt),  32'(eg_d));
    e_en = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = 14'h0;
    if (eg_d && dl) begin
      e_en = 1'b1; e_we = dw; e_be = dw ? be : 4'hF; e_addr = da[15:2];
    end else if (eg_i && il) begin
      e_en = 1'b1; e_be = 4'hF; e_addr = ia[15:2];
    end
    check_val("mem_en",   32'(bus.mem_en),   32'(e_en));
    check_val("mem_we",   32'(bus.mem_we),   32'(e_we));
    check_val("mem_be",   32'(bus.mem_be),   32'(e_be));
    check_val("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    if (e_we) check_val("mem_wdata", bus.mem_wdata, wd);
    if (eg_d || eg_i) begin
      r.own_d = eg_d;
      r.err   = eg_d ? !dl : !il;
      r.rdata = 32'h0;
      if (eg_d && dl && !dw) r.rdata = model_mem[da[15:2]];
      if (eg_i && il)        r.rdata = model_mem[ia[15:2]];
      if (eg_d && dl && dw)
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[da[15:2]][8*b +: 8] = wd[8*b +: 8];
      exp_q.push_back(r);
      last_d = eg_d;
      gseq = {gseq[2:0], eg_i};
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check_val("if_rvalid", 32'(bus.if_rvalid), 32'(!r.own_d));
      check_val("d_rvalid",  32'(bus.d_rvalid),  32'(r.own_d));
      if (r.own_d) begin
        check_val("d_rdata", bus.d_rdata, r.rdata);
        check_val("d_err",   32'(bus.d_err), 32'(r.err));
        last_rdata = bus.d_rdata;
      end else begin
        check_val("if_rdata", bus.if_rdata, r.rdata);
        check_val("if_err",   32'(bus.if_err), 32'(r.err));
        last_rdata = bus.if_rdata;
      end
    end else begin
      check_val("no_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      check_val("no_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    last_d = 1'b1;
    gseq = 4'h0;
    last_rdata = 32'h0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      model_mem[i] = mem[i];
    end
    mem[14'h2001] = 32'hDEAD_BEEF; model_mem[14'h2001] = 32'hDEAD_BEEF;
    mem[14'h0040] = 32'hAAAA_AAAA; model_mem[14'h0040] = 32'hAAAA_AAAA;

    // Requests held during reset must not be granted.
    drive(1'b1, 32'h0000_0200, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
    @(negedge clk); #1;
    check_quiet("reset");
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;

    // Conflict straight out of reset.
    gseq = 4'h0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
`ifdef RISCV_ARB_RR_EN
    check_val("conflict_seq", 32'(gseq), 32'h0000_000A);
`else
    check_val("conflict_seq", 32'(gseq), 32'h0000_0000);
`endif

    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_8004, 32'h0);
    check_val("load_8004", last_rdata, 32'hDEAD_BEEF);

    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'h1234_5678);
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_val("fetch_after_store", last_rdata, 32'hAAAA_5678);

    step(1'b1, 32'h0000_8000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0002, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0);
    step(1'b1, 32'h0000_7FFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0000_0104, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0);
    step(1'b1, 32'h0000_0104, 1'b1, 1'b1, 4'b1000, 32'h0000_0104, 32'h7700_0000);
    step(1'b1, 32'h0000_0104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_quiet("idle");

    // Reset between accept and response: the pending response is dropped.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_8004, 32'h0);
    #1;
    check_val("rst_mid_gnt", 32'(bus.d_gnt), 32'd1);
    #2 rst = 1'b1;
    #1 check_quiet("rst_mid_during");
    @(posedge clk); #1;
    check_quiet("rst_mid_edge");
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    last_d = 1'b1;
    #1 check_quiet("rst_mid_after");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom_range(0, 32'h0000_9000);
      rb = $urandom_range(0, 32'h0001_1000);
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), rb, $urandom);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
